// File: rtl/core_sequencer.sv
// Layer sequencer for the PE-array core: loads one kernel, streams activations,
// executes, then drains result vectors from the output FIFO into psum SRAM.
module core_sequencer #(
    parameter int row = 8,
    parameter int col = 8,
    parameter int AW  = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] num_act,
    input  logic [AW-1:0] act_base,
    input  logic [AW-1:0] w_base,
    input  logic [AW-1:0] psum_base,
    input  logic          ofifo_valid,
    output logic [33:0]   inst,
    output logic          xw_mode,
    output logic          sfp_reset,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE,
        W_RD,
        K_LOAD,
        K_DRAIN,
        A_RD,
        EXEC,
        DRAIN,
        DONE
    } state_t;

    // Both SRAMs idle: chip enables and write enables deasserted (active-low).
    localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

    localparam int BIT_OFIFO_RD = 6;
    localparam int BIT_L0_RD    = 3;
    localparam int BIT_L0_WR    = 2;
    localparam int BIT_EXECUTE  = 1;
    localparam int BIT_LOAD     = 0;

    state_t        state_q;
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] rdCnt_q;
    logic [AW-1:0] wrCnt_q;
    logic [AW-1:0] numAct_q;
    logic [AW-1:0] actBase_q;
    logic [AW-1:0] wBase_q;
    logic [AW-1:0] psumBase_q;
    logic [33:0]   inst_q;
    logic          xwMode_q;
    logic          sfpReset_q;
    logic          busy_q;
    logic          done_q;

    logic          l0Wr_d;
    logic          psumWr_d;
    logic          ofRd_d;
    logic [33:0]   instBase_d;
    logic [33:0]   drainWord_d;

    function automatic logic [33:0] xmemRead(input logic [33:0] w, input logic [AW-1:0] a);
        logic [33:0] r;
        r        = w;
        r[19]    = 1'b0;
        r[18]    = 1'b1;
        r[17:7]  = 11'(a);
        return r;
    endfunction

    function automatic logic [33:0] psumWrite(input logic [33:0] w, input logic [AW-1:0] a);
        logic [33:0] r;
        r        = w;
        r[32]    = 1'b0;
        r[31]    = 1'b0;
        r[30:20] = 11'(a);
        return r;
    endfunction

    // The 1-cycle SRAM read latency and the FIFO-read-to-write delay both key
    // off what the registered instruction word issued in the previous cycle.
    assign l0Wr_d   = ~inst_q[19] & inst_q[18];
    assign psumWr_d = inst_q[BIT_OFIFO_RD];
    assign ofRd_d   = ofifo_valid && (rdCnt_q != numAct_q);

    always_comb begin
        instBase_d            = IDLE_WORD;
        instBase_d[BIT_L0_WR] = l0Wr_d;
        drainWord_d           = instBase_d;
        if (ofRd_d) begin
            drainWord_d[BIT_OFIFO_RD] = 1'b1;
        end
        if (psumWr_d) begin
            drainWord_d = psumWrite(drainWord_d, psumBase_q + wrCnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rdCnt_q    <= '0;
            wrCnt_q    <= '0;
            numAct_q   <= '0;
            actBase_q  <= '0;
            wBase_q    <= '0;
            psumBase_q <= '0;
            inst_q     <= IDLE_WORD;
            xwMode_q   <= 1'b0;
            sfpReset_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            inst_q     <= instBase_d;
            xwMode_q   <= 1'b0;
            sfpReset_q <= 1'b0;
            done_q     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (start) begin
                        numAct_q   <= num_act;
                        actBase_q  <= act_base;
                        wBase_q    <= w_base;
                        psumBase_q <= psum_base;
                        cnt_q      <= '0;
                        rdCnt_q    <= '0;
                        wrCnt_q    <= '0;
                        busy_q     <= 1'b1;
                        if (num_act != '0) begin
                            sfpReset_q <= 1'b1;
                            state_q    <= W_RD;
                        end else begin
                            state_q    <= DONE;
                        end
                    end
                end
                W_RD: begin
                    inst_q   <= xmemRead(instBase_d, wBase_q + cnt_q);
                    xwMode_q <= 1'b1;
                    if (cnt_q == AW'(row - 1)) begin
                        cnt_q   <= '0;
                        state_q <= K_LOAD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                K_LOAD: begin
                    inst_q <= instBase_d | (34'd1 << BIT_L0_RD) | (34'd1 << BIT_LOAD);
                    if (cnt_q == AW'(row - 1)) begin
                        cnt_q   <= '0;
                        state_q <= K_DRAIN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                K_DRAIN: begin
                    if (cnt_q == AW'(col - 1)) begin
                        cnt_q   <= '0;
                        state_q <= A_RD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                A_RD: begin
                    inst_q <= xmemRead(instBase_d, actBase_q + cnt_q);
                    if (cnt_q == numAct_q - 1'b1) begin
                        cnt_q   <= '0;
                        state_q <= EXEC;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                EXEC: begin
                    inst_q <= instBase_d | (34'd1 << BIT_L0_RD) | (34'd1 << BIT_EXECUTE);
                    if (cnt_q == numAct_q - 1'b1) begin
                        cnt_q   <= '0;
                        rdCnt_q <= '0;
                        wrCnt_q <= '0;
                        state_q <= DRAIN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    inst_q <= drainWord_d;
                    if (ofRd_d) begin
                        rdCnt_q <= rdCnt_q + 1'b1;
                    end
                    if (psumWr_d) begin
                        wrCnt_q <= wrCnt_q + 1'b1;
                        if (wrCnt_q == numAct_q - 1'b1) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign inst      = inst_q;
    assign xw_mode   = xwMode_q;
    assign sfp_reset = sfpReset_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: stimulus queues the expected SRAM/array
// events of each layer, an independent monitor pops them as the DUT emits them.
module tb_core_sequencer;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int AW  = 11;
    localparam logic [33:0] IDLE_WORD = (34'd1 << 32) | (34'd1 << 31) | (34'd1 << 19) | (34'd1 << 18);

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] num_act;
    logic [AW-1:0] act_base;
    logic [AW-1:0] w_base;
    logic [AW-1:0] psum_base;
    logic          ofifo_valid;
    logic [33:0]   inst;
    logic          xw_mode;
    logic          sfp_reset;
    logic          busy;
    logic          done;

    typedef enum logic [2:0] {EV_SFP, EV_READ, EV_LOAD, EV_EXEC, EV_WRITE, EV_OFRD, EV_DONE} evKind_t;
    typedef struct {
        evKind_t    kind;
        logic [10:0] addr;
        logic        xw;
    } ev_t;

    ev_t expQ[$];
    int  checks;
    int  errors;

    core_sequencer #(.row(ROW), .col(COL), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_act    (num_act),
        .act_base   (act_base),
        .w_base     (w_base),
        .psum_base  (psum_base),
        .ofifo_valid(ofifo_valid),
        .inst       (inst),
        .xw_mode    (xw_mode),
        .sfp_reset  (sfp_reset),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
        end
    endtask

    task automatic pushEv(input evKind_t k, input logic [10:0] a, input logic x);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.xw   = x;
        expQ.push_back(e);
    endtask

    task automatic popEv(input evKind_t k, input logic [10:0] a, input logic x);
        ev_t e;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_event: actual %s addr=%h xw=%b, required no event", k.name(), a, x);
        end else begin
            e = expQ.pop_front();
            if (e.kind != k || ((k == EV_READ || k == EV_WRITE) && e.addr != a) || (k == EV_READ && e.xw != x)) begin
                errors++;
                $display("[TB] FAIL event_order: actual %s addr=%h xw=%b, required %s addr=%h xw=%b",
                         k.name(), a, x, e.kind.name(), e.addr, e.xw);
            end
        end
    endtask

    // Monitor: samples 1 time unit after each edge and checks event order plus
    // the one-cycle follow relations of l0_wr and psum writes.
    initial begin
        logic prevRead, prevOfrd, vEdge, rEdge, curRead, curWrite;
        prevRead = 1'b0;
        prevOfrd = 1'b0;
        forever begin
            @(posedge clk);
            vEdge = ofifo_valid;
            rEdge = reset;
            #1;
            curRead  = !inst[19] && inst[18];
            curWrite = !inst[32] && !inst[31];
            checkOutput("unused_bits_zero", 64'(inst[33] | inst[5] | inst[4]), 64'd0);
            if (!rEdge) begin
                if (prevRead || inst[2]) checkOutput("l0_wr_follows_read", 64'(inst[2]), 64'(prevRead));
                if (prevOfrd || curWrite) checkOutput("psum_wr_follows_ofifo_rd", 64'(curWrite), 64'(prevOfrd));
                if (inst[6]) checkOutput("ofifo_rd_needs_valid", 64'(vEdge), 64'd1);
            end
            if (sfp_reset) popEv(EV_SFP, 11'h0, 1'b0);
            if (curRead)   popEv(EV_READ, inst[17:7], xw_mode);
            if (inst[0])   popEv(EV_LOAD, 11'h0, 1'b0);
            if (inst[1])   popEv(EV_EXEC, 11'h0, 1'b0);
            if (curWrite)  popEv(EV_WRITE, inst[30:20], 1'b0);
            if (inst[6])   popEv(EV_OFRD, 11'h0, 1'b0);
            if (done)      popEv(EV_DONE, 11'h0, 1'b0);
            prevRead = curRead;
            prevOfrd = inst[6];
        end
    end

    task automatic pushLayer(input logic [10:0] n, input logic [10:0] act, input logic [10:0] w, input logic [10:0] psum);
        if (n == 0) begin
            pushEv(EV_DONE, 11'h0, 1'b0);
        end else begin
            pushEv(EV_SFP, 11'h0, 1'b0);
            for (int i = 0; i < ROW; i++) pushEv(EV_READ, w + 11'(i), 1'b1);
            for (int i = 0; i < ROW; i++) pushEv(EV_LOAD, 11'h0, 1'b0);
            for (int i = 0; i < int'(n); i++) pushEv(EV_READ, act + 11'(i), 1'b0);
            for (int i = 0; i < int'(n); i++) pushEv(EV_EXEC, 11'h0, 1'b0);
            for (int k = 0; k < int'(n); k++) begin
                pushEv(EV_OFRD, 11'h0, 1'b0);
                pushEv(EV_WRITE, psum + 11'(k), 1'b0);
            end
            pushEv(EV_DONE, 11'h0, 1'b0);
        end
    endtask

    // One-cycle start pulse, then scramble the inputs the layer must have latched.
    task automatic applyStimulus(input logic [10:0] n, input logic [10:0] act, input logic [10:0] w, input logic [10:0] psum);
        @(negedge clk);
        start     = 1'b1;
        num_act   = n;
        act_base  = act;
        w_base    = w;
        psum_base = psum;
        @(negedge clk);
        start     = 1'b0;
        num_act   = 11'h5A5;
        act_base  = 11'h3C3;
        w_base    = 11'h155;
        psum_base = 11'h2AA;
    endtask

    task automatic runLayer(input logic [10:0] n, input logic [10:0] act, input logic [10:0] w, input logic [10:0] psum,
                            input logic [7:0] pat, input int patLen, input logic validEarly, input logic startDuringExec);
        int execSeen;
        int cyc;
        pushLayer(n, act, w, psum);
        applyStimulus(n, act, w, psum);
        if (n == 0) begin
            checkOutput("noop_cycle1_busy_done", {62'd0, busy, done}, 64'b10);
            @(negedge clk);
            checkOutput("noop_cycle2_busy_done", {62'd0, busy, done}, 64'b01);
            @(negedge clk);
            checkOutput("noop_cycle3_busy_done", {62'd0, busy, done}, 64'b00);
            return;
        end
        execSeen    = 0;
        cyc         = 0;
        ofifo_valid = validEarly;
        while (cyc < 300) begin
            start = 1'b0;
            if (inst[1] === 1'b1) begin
                execSeen++;
                if (startDuringExec && execSeen == 1) start = 1'b1;
            end
            if (execSeen == int'(n)) break;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        checkOutput("exec_cycles_seen", 64'(execSeen), 64'(n));
        for (int i = 0; i < patLen; i++) begin
            ofifo_valid = pat[i];
            @(negedge clk);
        end
        ofifo_valid = 1'b1;
        cyc = 0;
        while (done !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("done_pulse_done_busy", {62'd0, done, busy}, 64'b10);
        ofifo_valid = 1'b0;
        @(negedge clk);
        checkOutput("done_single_cycle", {62'd0, done, busy}, 64'b00);
    endtask

    initial begin
        int cyc;
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        start       = 1'b1;
        num_act     = 11'd4;
        act_base    = '0;
        w_base      = '0;
        psum_base   = '0;
        ofifo_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", {26'd0, inst, xw_mode, sfp_reset, busy, done}, {26'd0, IDLE_WORD, 4'b0000});
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("idle_after_reset", {29'd0, inst, busy}, {29'd0, IDLE_WORD, 1'b0});

        runLayer(11'd4, 11'h100, 11'h010, 11'h200, 8'h0F, 4, 1'b0, 1'b0);
        runLayer(11'd3, 11'h7FE, 11'h7FC, 11'h020, 8'b0000_1101, 4, 1'b1, 1'b0);
        runLayer(11'd0, 11'h111, 11'h222, 11'h333, 8'h00, 0, 1'b0, 1'b0);
        runLayer(11'd2, 11'h050, 11'h060, 11'h070, 8'h03, 2, 1'b0, 1'b1);

        pushLayer(11'd4, 11'h400, 11'h500, 11'h600);
        applyStimulus(11'd4, 11'h400, 11'h500, 11'h600);
        cyc = 0;
        while (inst[1] !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("reached_exec", 64'(inst[1]), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_idle_word", {26'd0, inst, xw_mode, sfp_reset, busy, done}, {26'd0, IDLE_WORD, 4'b0000});
        reset = 1'b0;
        expQ.delete();
        repeat (3) @(negedge clk);
        checkOutput("abort_stays_idle", {62'd0, busy, done}, 64'd0);

        runLayer(11'd4, 11'h300, 11'h040, 11'h7FE, 8'b0000_0101, 4, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
